// File: rtl/core_cpu_pkg.sv
// rtl/core_cpu_pkg.sv - shared opcodes, instruction field positions and dispatch FSM encoding
package core_cpu_pkg;

    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op >= OP_AND) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_dispatch_regfile.sv
// rtl/alu_dispatch_regfile.sv - 16 x DW register file, one sync write port, three async read ports
// Ports: clk, rst (sync, active-high); i_we/i_waddr/i_wdata write port;
//        i_raddr0..2 -> o_rdata0..2 combinational reads.
// Build option: ALU_DISPATCH_R0_ZERO_EN hard-wires register 0 to zero.
module alu_dispatch_regfile #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [3:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [3:0]    i_raddr0,
    input  logic [3:0]    i_raddr1,
    input  logic [3:0]    i_raddr2,
    output logic [DW-1:0] o_rdata0,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2
);

    logic [DW-1:0] r_mem [16];
    logic          w_we;

`ifdef ALU_DISPATCH_R0_ZERO_EN
    // Writes to r0 are dropped; reads of r0 are forced to zero.
    assign w_we     = i_we && (i_waddr != 4'd0);
    assign o_rdata0 = (i_raddr0 == 4'd0) ? '0 : r_mem[i_raddr0];
    assign o_rdata1 = (i_raddr1 == 4'd0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 4'd0) ? '0 : r_mem[i_raddr2];
`else
    assign w_we     = i_we;
    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - single-issue dispatcher: register file, operand fetch, ALU issue, writeback
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instr instruction handshake;
//        ld_valid/ld_addr/ld_data register preload; alu_opcode/alu_a/alu_b to ALU, alu_out back;
//        wb_valid/wb_addr/wb_data writeback pulse; dbg_addr/dbg_data register peek;
//        err sticky illegal-opcode flag, err_clr clears it.
// Build option: ALU_DISPATCH_R0_ZERO_EN (register 0 reads as zero, writes discarded).
module alu_dispatch
    import core_cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    input  logic          ld_valid,
    input  logic [3:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_out,
    output logic          wb_valid,
    output logic [3:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic          err,
    input  logic          err_clr
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_op;
    logic [3:0]    r_rd;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_err;

    logic [3:0]    w_opc;
    logic          w_legal;
    logic          w_accept;
    logic          w_ld_en;
    logic          w_wb_en;
    logic          w_rf_we;
    logic [3:0]    w_rf_waddr;
    logic [DW-1:0] w_rf_wdata;
    logic [DW-1:0] w_rs1_data;
    logic [DW-1:0] w_rs2_data;

    assign w_opc    = in_instr[OPC_HI:OPC_LO];
    assign w_legal  = is_legal_op(w_opc);
    assign w_accept = in_valid && in_ready;

    // Preload and writeback never coincide (IDLE vs WB), so a simple mux suffices.
    assign w_ld_en    = ld_valid && (r_state == ST_IDLE) && !rst;
    assign w_wb_en    = (r_state == ST_WB) && !rst;
    assign w_rf_we    = w_ld_en || w_wb_en;
    assign w_rf_waddr = w_wb_en ? r_rd : ld_addr;
    assign w_rf_wdata = w_wb_en ? alu_out : ld_data;

    alu_dispatch_regfile #(.DW(DW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_rf_we),
        .i_waddr  (w_rf_waddr),
        .i_wdata  (w_rf_wdata),
        .i_raddr0 (in_instr[RS1_HI:RS1_LO]),
        .i_raddr1 (in_instr[RS2_HI:RS2_LO]),
        .i_raddr2 (dbg_addr),
        .o_rdata0 (w_rs1_data),
        .o_rdata1 (w_rs2_data),
        .o_rdata2 (dbg_data)
    );

    // Outputs are gated by rst so an in-flight instruction never reaches the
    // ALU or writeback during the reset cycle.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        alu_opcode  = 4'b0000;
        alu_a       = '0;
        alu_b       = '0;
        wb_valid    = 1'b0;
        wb_addr     = 4'd0;
        wb_data     = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = !ld_valid && !rst;
                if (w_accept && w_legal) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!rst) begin
                    alu_opcode = r_op;
                    alu_a      = r_a;
                    alu_b      = r_b;
                end
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                if (!rst) begin
                    wb_valid = 1'b1;
                    wb_addr  = r_rd;
                    wb_data  = alu_out;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= 4'd0;
            r_rd    <= 4'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= w_opc;
                r_rd <= in_instr[RD_HI:RD_LO];
                r_a  <= w_rs1_data;
                r_b  <= w_rs2_data;
            end
            // A new illegal opcode wins over a simultaneous clear.
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err = r_err;

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter DW, default 16, datapath/register width; all data ports below are DW bits.
REQ-002 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  instruction word offered.
REQ-005 SHALL have port in_ready  output  1  instruction accepted when in_valid && in_ready.
REQ-006 SHALL have port in_instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-007 SHALL have port ld_valid, ld_addr[3:0], ld_data[DW-1:0]  input  register preload write.
REQ-008 SHALL have port alu_opcode  output  4  opcode to the logical ALU.
REQ-009 SHALL have port alu_a, alu_b  output  DW  operands to the logical ALU.
REQ-010 SHALL have port alu_out  input  DW  registered ALU result, valid one cycle after issue.
REQ-011 SHALL have port wb_valid  output  1  one-cycle pulse per register writeback.
REQ-012 SHALL have port wb_addr[3:0], wb_data[DW-1:0]  output  writeback address/data, valid with wb_valid.
REQ-013 SHALL have port dbg_addr[3:0] input, dbg_data[DW-1:0] output  combinational register read.
REQ-014 SHALL have port err  output  1  sticky illegal-opcode flag; err_clr  input  1  clears it.

Function
REQ-015 SHALL implement a 16 x DW register file, written only by preload or writeback.
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WB -> IDLE; busy whenever state != IDLE.
REQ-017 SHALL assert in_ready only in IDLE with ld_valid low; preload has priority over instruction accept.
REQ-018 SHALL on accept latch opcode/rd and read rs1/rs2 into operand registers; go to ISSUE if opcode in 4'b1000..4'b1101, else set err, stay IDLE, no writeback.
REQ-019 SHALL in ISSUE drive alu_opcode/alu_a/alu_b from latched values for exactly one cycle; 4'b0000 and zero operands in all other states.
REQ-020 SHALL in WB capture alu_out into rd, pulse wb_valid with wb_addr=rd, wb_data=alu_out.
REQ-021 SHALL give accept-to-wb_valid latency 2 cycles and max throughput 1 instruction per 3 cycles.
REQ-022 SHALL make a register written in WB visible to an instruction accepted the following cycle (no hazard).
REQ-023 SHALL ignore ld_valid outside IDLE (no write, no queueing).
REQ-024 SHALL, when err_clr and a new illegal opcode coincide, leave err set.

Reset
REQ-025 SHALL on rst: state IDLE, all registers 0, err 0, wb_valid 0, alu outputs 0, any in-flight instruction dropped without writeback.
REQ-026 SHALL hold in_ready low during the rst cycle.

Configuration
REQ-027 SHALL, with ALU_DISPATCH_R0_ZERO_EN defined, hard-wire register 0 to zero: reads return 0, writes (preload and writeback) discarded, wb_valid still pulses.
REQ-028 SHALL, without ALU_DISPATCH_R0_ZERO_EN, treat register 0 as an ordinary register.

Structure
REQ-029 SHALL place opcode constants (AND 1000, OR 1001, NAND 1010, NOR 1011, NOT 1100, XOR 1101), instruction field positions and FSM state encoding in shared package core_cpu_pkg.
REQ-030 SHALL factor the register file into sub-module alu_dispatch_regfile (1 sync write, 3 async read ports).

Verification
REQ-031 Preload r1=16'hF0F0, r2=16'h0FF0; instr 16'h8312 (AND r3) -> wb_valid 2 cycles after accept, wb_addr=3, wb_data=16'h00F0.
REQ-032 r1=16'h00FF, instr 16'hC41x (NOT r4) -> r4=16'hFF00; then instr 16'hD541 (XOR r5=r4^r1) accepted next cycle -> r5=16'hFFFF.
REQ-033 Instr 16'h2312 (illegal) -> err=1, no wb_valid, in_ready stays high; err_clr pulse -> err=0.
REQ-034 ld_valid and in_valid same IDLE cycle -> preload written, in_ready low, instruction accepted next cycle.
REQ-035 rst asserted in WB of 16'h9312 -> no wb_valid, r3=0, state IDLE next cycle.
REQ-036 With ALU_DISPATCH_R0_ZERO_EN: preload r0=16'h1234, instr 16'h9000 -> wb_data=16'h0000, dbg_data(r0)=0.
